motor_drive_ctrl: RTL and testbench
===================================

Name: motor_drive_ctrl

Overview:
- Downstream consumer of the bot FSM's 3-bit state.
- Translates each state into left and right wheel PWM and direction outputs, with ramped acceleration and deceleration.
- Drives the gripper pulse during PICK_BOX and reports illegal state codes.
- Sits between the FSM controller and the H-bridge/gripper pins.

Parameters:
- PWM_BITS, 8: PWM counter and duty width.
- CRUISE_DUTY, 200: duty for DRIVE_BOTH.
- TURN_DUTY, 128: duty for turning wheels.
- RAMP_STEP, 8: duty change per ramp tick.
- RAMP_DIV, 16: clock cycles per ramp tick.
- PICK_CYCLES, 100: gripper pulse length in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- state  input  3  FSM state: 000 IDLE, 001 DRIVE_BOTH, 010 TURN_LEFT, 011 TURN_RIGHT, 100 U_TURN, 101 PICK_BOX.
- left_pwm  output  1  left motor PWM.
- right_pwm  output  1  right motor PWM.
- left_dir  output  1  left direction, 0 = forward, 1 = reverse.
- right_dir  output  1  right direction, 0 = forward, 1 = reverse.
- gripper_en  output  1  gripper actuator enable.
- pick_done  output  1  one-cycle pulse when the gripper pulse completes.
- fault  output  1  high while state is 110 or 111.

Behaviour:
- Reset:
  - Applies when reset=0 at a clk edge.
  - All outputs 0, PWM counter 0, ramp counter 0, current and applied duties 0, dirs forward, previous-state register 000.
  - Reset mid-operation aborts any ramp or gripper pulse immediately.
- Per-state targets (duty, dir), left then right:
  - IDLE: 0/fwd, 0/fwd.
  - DRIVE_BOTH: CRUISE/fwd, CRUISE/fwd.
  - TURN_LEFT: 0/fwd, TURN/fwd.
  - TURN_RIGHT: TURN/fwd, 0/fwd.
  - U_TURN: TURN/rev, TURN/fwd.
  - PICK_BOX: 0/fwd, 0/fwd.
  - 110 and 111: handled as IDLE, with fault=1 registered (one-cycle latency).
- PWM:
  - Free-running counter 0 to 2^PWM_BITS-1, wraps to 0.
  - Output bit = (counter < applied_duty), registered.
  - applied_duty loads current_duty only on the cycle the counter equals its max, so there are no mid-period glitches.
  - Duty 255 gives 255/256 high; 100% is not reachable.
- Ramp:
  - Ramp counter 0 to RAMP_DIV-1; a tick fires when it equals RAMP_DIV-1.
  - On each tick, per wheel:
    - If current dir != target dir: duty = duty-STEP when duty > STEP, otherwise duty = 0 and dir = target dir in the same update.
    - Else if duty < target: duty = min(duty+STEP, target).
    - Else if duty > target: duty = max(duty-STEP, target).
    - Computed at PWM_BITS+1 width; no overshoot, no wrap.
  - A direction change always passes through duty 0.
- Hard stop:
  - While state is IDLE, PICK_BOX or illegal, current_duty and applied_duty are forced to 0 every cycle, bypassing the ramp and the period boundary.
  - PWM outputs go low on the first clk edge at which such a state is sampled.
  - Dirs return to forward on the same edge.
- Gripper:
  - On entry to PICK_BOX (state==101 and prev!=101), gripper_en rises the next cycle and stays high exactly PICK_CYCLES cycles.
  - pick_done pulses for one cycle on the cycle after gripper_en falls.
  - If state leaves 101 before completion, gripper_en drops the next cycle, no pick_done is issued, and the counter clears.
  - Re-entering PICK_BOX restarts a full pulse.
- Transitions between moving states retarget the ramp immediately; the ramp counter is never reset by a state change.

Test Plan:
- Reset low for 3 cycles with state=001 -> all outputs 0, dirs 0, fault 0. Release reset.
- IDLE->DRIVE_BOTH -> duty reaches 200 after 25 ticks (400 cycles). Steady left_pwm and right_pwm high 200 of every 256 cycles, dirs 0.
- DRIVE_BOTH (settled)->U_TURN:
  - Left ramps 200->0 over 25 ticks, left_dir flips to 1 on that tick, then ramps to 128 over 16 ticks.
  - Right ramps to 128 over 9 ticks with right_dir 0 throughout.
- DRIVE_BOTH mid-ramp (duty 96)->IDLE -> both PWM low on the next edge, applied duty 0 without waiting for counter wrap.
- Enter PICK_BOX -> gripper_en high exactly 100 cycles, then pick_done=1 for one cycle. Repeat, leaving at cycle 50 -> gripper_en falls next cycle, pick_done never asserts.
- Drive state=110 -> fault=1 next cycle, PWM low. Then state=001 -> fault=0 and ramp-up begins. Assert reset during ramp -> duty and outputs return to 0.

Source files
------------

// File: rtl/motor_drive_ctrl.sv
// Motor drive controller: maps the bot FSM state onto ramped left/right wheel PWM and
// direction, times the gripper pulse in PICK_BOX and flags illegal state codes.
module motor_drive_ctrl #(
    parameter int PWM_BITS    = 8,
    parameter int CRUISE_DUTY = 200,
    parameter int TURN_DUTY   = 128,
    parameter int RAMP_STEP   = 8,
    parameter int RAMP_DIV    = 16,
    parameter int PICK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_dir,
    output logic       right_dir,
    output logic       gripper_en,
    output logic       pick_done,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_DRIVE = 3'b001,
        ST_LEFT  = 3'b010,
        ST_RIGHT = 3'b011,
        ST_UTURN = 3'b100,
        ST_PICK  = 3'b101
    } bot_state_e;

    typedef struct packed {
        logic                dir;
        logic [PWM_BITS-1:0] duty;
    } wheel_t;

    localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int GC_W = $clog2(PICK_CYCLES + 1);

    localparam logic [PWM_BITS-1:0] CRUISE_D  = PWM_BITS'(CRUISE_DUTY);
    localparam logic [PWM_BITS-1:0] TURN_D    = PWM_BITS'(TURN_DUTY);
    localparam logic [PWM_BITS-1:0] STEP_D    = PWM_BITS'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(RAMP_STEP);
    localparam logic [RC_W-1:0]     RAMP_LAST = RC_W'(RAMP_DIV - 1);
    localparam logic [GC_W-1:0]     PICK_LAST = GC_W'(PICK_CYCLES);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [RC_W-1:0]     ramp_cnt_q;
    wheel_t              cur_l_q, cur_r_q, cur_l_d, cur_r_d;
    wheel_t              tgt_l, tgt_r;
    logic [PWM_BITS-1:0] app_l_q, app_r_q, app_l_d, app_r_d;
    logic                left_pwm_q, right_pwm_q;
    logic [2:0]          prev_state_q;
    logic [GC_W-1:0]     grip_cnt_q, grip_cnt_d;
    logic                gripper_q, gripper_d;
    logic                pick_done_q, pick_done_d;
    logic                fault_q;
    logic                hard_stop, ramp_tick, pwm_wrap, pick_entry;

    assign ramp_tick  = (ramp_cnt_q == RAMP_LAST);
    assign pwm_wrap   = &pwm_cnt_q;
    assign pick_entry = (state == ST_PICK) && (prev_state_q != ST_PICK);

    // One ramp step toward the target; comparisons run one bit wider so nothing wraps.
    function automatic wheel_t ramp_wheel(input wheel_t cur, input wheel_t tgt);
        wheel_t            nxt;
        logic [PWM_BITS:0] cur_w, tgt_w;
        nxt   = cur;
        cur_w = {1'b0, cur.duty};
        tgt_w = {1'b0, tgt.duty};
        if (cur.dir != tgt.dir) begin
            if (cur_w > STEP_W) begin
                nxt.duty = cur.duty - STEP_D;
            end else begin
                nxt.duty = '0;
                nxt.dir  = tgt.dir;
            end
        end else if (cur_w < tgt_w) begin
            nxt.duty = (cur_w + STEP_W >= tgt_w) ? tgt.duty : cur.duty + STEP_D;
        end else if (cur_w > tgt_w) begin
            nxt.duty = (cur_w >= tgt_w + STEP_W) ? cur.duty - STEP_D : tgt.duty;
        end
        return nxt;
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        tgt_l     = '0;
        tgt_r     = '0;
        hard_stop = 1'b0;
        case (state)
            ST_DRIVE: begin
                tgt_l.duty = CRUISE_D;
                tgt_r.duty = CRUISE_D;
            end
            ST_LEFT:  tgt_r.duty = TURN_D;
            ST_RIGHT: tgt_l.duty = TURN_D;
            ST_UTURN: begin
                tgt_l.dir  = 1'b1;
                tgt_l.duty = TURN_D;
                tgt_r.duty = TURN_D;
            end
            ST_IDLE, ST_PICK: hard_stop = 1'b1;
            default:          hard_stop = 1'b1;
        endcase
    end

    always_comb begin
        cur_l_d = cur_l_q;
        cur_r_d = cur_r_q;
        app_l_d = app_l_q;
        app_r_d = app_r_q;
        if (hard_stop) begin
            cur_l_d = '0;
            cur_r_d = '0;
            app_l_d = '0;
            app_r_d = '0;
        end else begin
            if (ramp_tick) begin
                cur_l_d = ramp_wheel(cur_l_q, tgt_l);
                cur_r_d = ramp_wheel(cur_r_q, tgt_r);
            end
            // Applied duty only moves at the period boundary to avoid glitched pulses.
            if (pwm_wrap) begin
                app_l_d = cur_l_q.duty;
                app_r_d = cur_r_q.duty;
            end
        end
    end

    always_comb begin
        gripper_d   = gripper_q;
        grip_cnt_d  = grip_cnt_q;
        pick_done_d = 1'b0;
        if (pick_entry) begin
            gripper_d  = 1'b1;
            grip_cnt_d = GC_W'(1);
        end else if (gripper_q) begin
            if (grip_cnt_q == PICK_LAST) begin
                gripper_d   = 1'b0;
                grip_cnt_d  = '0;
                pick_done_d = 1'b1;
            end else if (state != ST_PICK) begin
                gripper_d  = 1'b0;
                grip_cnt_d = '0;
            end else begin
                grip_cnt_d = grip_cnt_q + GC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_q    <= '0;
            ramp_cnt_q   <= '0;
            cur_l_q      <= '0;
            cur_r_q      <= '0;
            app_l_q      <= '0;
            app_r_q      <= '0;
            left_pwm_q   <= 1'b0;
            right_pwm_q  <= 1'b0;
            prev_state_q <= 3'b000;
            grip_cnt_q   <= '0;
            gripper_q    <= 1'b0;
            pick_done_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            pwm_cnt_q    <= pwm_cnt_q + PWM_BITS'(1);
            ramp_cnt_q   <= ramp_tick ? '0 : ramp_cnt_q + RC_W'(1);
            cur_l_q      <= cur_l_d;
            cur_r_q      <= cur_r_d;
            app_l_q      <= app_l_d;
            app_r_q      <= app_r_d;
            left_pwm_q   <= !hard_stop && (pwm_cnt_q < app_l_q);
            right_pwm_q  <= !hard_stop && (pwm_cnt_q < app_r_q);
            prev_state_q <= state;
            grip_cnt_q   <= grip_cnt_d;
            gripper_q    <= gripper_d;
            pick_done_q  <= pick_done_d;
            fault_q      <= state[2] & state[1];
        end
    end

    assign left_pwm   = left_pwm_q;
    assign right_pwm  = right_pwm_q;
    assign left_dir   = cur_l_q.dir;
    assign right_dir  = cur_r_q.dir;
    assign gripper_en = gripper_q;
    assign pick_done  = pick_done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Scoreboard bench for motor_drive_ctrl: expectations are queued as each scenario is driven
// and popped as the matching measurement of the DUT pins completes.
module tb_motor_drive_ctrl;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_DRIVE = 3'b001;
    localparam logic [2:0] S_UTURN = 3'b100;
    localparam logic [2:0] S_PICK  = 3'b101;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state = 3'b001;
    logic       left_pwm, right_pwm, left_dir, right_dir, gripper_en, pick_done, fault;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    string tag_q[$];
    int    val_q[$];

    motor_drive_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .left_pwm  (left_pwm),
        .right_pwm (right_pwm),
        .left_dir  (left_dir),
        .right_dir (right_dir),
        .gripper_en(gripper_en),
        .pick_done (pick_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Edges since reset release; DUT PWM/ramp counters track cyc mod 256 / mod 16.
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic push_exp(input string tag, input int val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic observe(input logic [31:0] actual);
        string t;
        int    v;
        if (tag_q.size() == 0) begin
            check("sb_underflow", 32'(tag_q.size()), 1);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            check(t, actual, v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int n);
        if (cyc > n) check("sched_late", cyc, n);
        while (cyc < n) step();
    endtask

    task automatic count_win(input int n, output int lc, output int rc);
        lc = 0;
        rc = 0;
        repeat (n) begin
            step();
            lc += int'(left_pwm);
            rc += int'(right_pwm);
        end
    endtask

    function automatic int next_mult(input int base, input int k);
        return ((base / k) + 1) * k;
    endfunction

    function automatic logic [6:0] outs();
        return {left_pwm, right_pwm, left_dir, right_dir, gripper_en, pick_done, fault};
    endfunction

    function automatic logic [4:0] flt_view();
        return {fault, left_pwm, right_pwm, left_dir, right_dir};
    endfunction

    // Enter PICK_BOX and watch 150 edges; abort_at>0 drops back to IDLE after that edge.
    task automatic run_pick(input int abort_at);
        int first_hi, g_cnt, pd_cnt, pd_at, pwm_hi;
        first_hi = -1; g_cnt = 0; pd_cnt = 0; pd_at = -1; pwm_hi = 0;
        state = S_PICK;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (gripper_en) begin
                g_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (pick_done) begin
                pd_cnt++;
                pd_at = i;
            end
            pwm_hi += int'(left_pwm) + int'(right_pwm);
            if (i == abort_at) state = S_IDLE;
        end
        state = S_IDLE;
        step();
        observe(first_hi);
        observe(g_cnt);
        observe(pd_cnt);
        observe(pd_at);
        observe(pwm_hi);
    endtask

    initial begin
        int lc, rc, m, l, flip, ldrop, rdir_any, dir_any;
        int exp_l[4], exp_r[4];

        // Reset held with DRIVE_BOTH on the input.
        reset = 1'b0;
        state = S_DRIVE;
        repeat (3) step();
        push_exp("reset_outputs", 0);
        observe(outs());
        state = S_IDLE;
        reset = 1'b1;

        // IDLE -> DRIVE_BOTH at edge 256; each window shows the duty loaded at its start.
        exp_l = '{0, 120, 200, 200};
        for (int w = 0; w < 4; w++) begin
            push_exp($sformatf("drive_win%0d_left", w), exp_l[w]);
            push_exp($sformatf("drive_win%0d_right", w), exp_l[w]);
        end
        push_exp("drive_dirs", 0);
        goto_cyc(256);
        state = S_DRIVE;
        dir_any = 0;
        for (int w = 0; w < 4; w++) begin
            lc = 0;
            rc = 0;
            repeat (256) begin
                step();
                lc += int'(left_pwm);
                rc += int'(right_pwm);
                dir_any |= int'(left_dir | right_dir);
            end
            observe(lc);
            observe(rc);
        end
        observe(dir_any);

        // Settled DRIVE_BOTH -> U_TURN at a period boundary.
        m = cyc;
        exp_l = '{200, 80, 48, 128};
        exp_r = '{200, 128, 128, 128};
        for (int w = 0; w < 4; w++) begin
            push_exp($sformatf("uturn_win%0d_left", w), exp_l[w]);
            push_exp($sformatf("uturn_win%0d_right", w), exp_r[w]);
        end
        push_exp("uturn_left_flip_offset", 400);
        push_exp("uturn_left_dir_dropped", 0);
        push_exp("uturn_right_dir", 0);
        state = S_UTURN;
        flip = -1; ldrop = 0; rdir_any = 0;
        for (int w = 0; w < 4; w++) begin
            lc = 0;
            rc = 0;
            repeat (256) begin
                step();
                lc += int'(left_pwm);
                rc += int'(right_pwm);
                if (!left_dir && flip >= 0) ldrop = 1;
                if (left_dir && flip < 0) flip = cyc - m;
                rdir_any |= int'(right_dir);
            end
            observe(lc);
            observe(rc);
        end
        observe(flip);
        observe(ldrop);
        observe(rdir_any);

        // Mid-ramp stop: duty 96 is applied at l, then IDLE inside the high phase.
        state = S_IDLE;
        l = next_mult(cyc + 256, 256);
        push_exp("stop_pwm_before", 3);
        push_exp("stop_pwm_after", 0);
        push_exp("stop_rest_of_period", 0);
        goto_cyc(l - 208);
        state = S_DRIVE;
        goto_cyc(l + 50);
        observe({left_pwm, right_pwm});
        state = S_IDLE;
        step();
        observe({left_pwm, right_pwm});
        count_win(l + 512 - cyc, lc, rc);
        observe(lc + rc);

        // Full gripper pulse, aborted pulse at cycle 50, then a full restart.
        push_exp("pick1_first_high", 1);
        push_exp("pick1_high_cycles", 100);
        push_exp("pick1_done_count", 1);
        push_exp("pick1_done_at", 101);
        push_exp("pick1_pwm_high", 0);
        run_pick(0);
        push_exp("pick2_first_high", 1);
        push_exp("pick2_high_cycles", 50);
        push_exp("pick2_done_count", 0);
        push_exp("pick2_done_at", -1);
        push_exp("pick2_pwm_high", 0);
        run_pick(50);
        push_exp("pick3_first_high", 1);
        push_exp("pick3_high_cycles", 100);
        push_exp("pick3_done_count", 1);
        push_exp("pick3_done_at", 101);
        push_exp("pick3_pwm_high", 0);
        run_pick(0);

        // Settled U_TURN, then illegal codes, then recovery ramp and a mid-ramp reset.
        push_exp("fault_before", 5'b01110);
        push_exp("fault_110_on", 5'b10000);
        push_exp("fault_111_held", 5'b10000);
        push_exp("fault_cleared", 0);
        push_exp("recover_win0_left", 0);
        push_exp("recover_win0_right", 0);
        push_exp("recover_ramp_left", 100);
        push_exp("recover_ramp_right", 100);
        push_exp("reset_mid_pwm_before", 3);
        push_exp("reset_mid_outputs", 0);
        push_exp("reset_mid_held", 0);
        push_exp("post_reset_win0_left", 0);
        push_exp("post_reset_win0_right", 0);
        push_exp("post_reset_win1_left", 120);
        push_exp("post_reset_win1_right", 120);
        state = S_UTURN;
        l = next_mult(cyc + 700, 256);
        goto_cyc(l + 10);
        observe(flt_view());
        state = 3'b110;
        step();
        observe(flt_view());
        l = next_mult(cyc, 256);
        goto_cyc(l - 100);
        state = 3'b111;
        goto_cyc(l);
        observe(flt_view());
        state = S_DRIVE;
        step();
        observe(flt_view());
        count_win(255, lc, rc);
        observe(lc);
        observe(rc);
        count_win(100, lc, rc);
        observe(lc);
        observe(rc);
        observe({left_pwm, right_pwm});
        reset = 1'b0;
        step();
        observe(outs());
        step();
        observe(outs());
        reset = 1'b1;
        count_win(256, lc, rc);
        observe(lc);
        observe(rc);
        count_win(256, lc, rc);
        observe(lc);
        observe(rc);

        check("scoreboard_leftover", 32'(tag_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
